// File: rtl/mod_m_counter.sv
// Free-running modulo-M up-counter with count enable and a combinational
// carry-out that is high while enabled at the terminal count M-1.
module mod_m_counter #(
  parameter  int M  = 10,
  localparam int CW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          co
);

  localparam logic [CW-1:0] LAST = CW'(M - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  // ">=" rather than "==" so any out-of-range value also reloads 0.
  // For M=1 this is always true, which pins cnt at 0.
  assign at_last = (cnt_q >= LAST);

  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  // rst is active-low despite its name.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign co  = en && (cnt_q == LAST);

endmodule

// File: tb/tb_mod_m_counter.sv
// Directed testbench for mod_m_counter across M = 10, 1000, 6, 1 and 2.
module tb_mod_m_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic       rst10 = 1'b0, en10 = 1'b0, co10;
  logic [3:0] cnt10;
  logic       rst1000 = 1'b0, en1000 = 1'b0, co1000;
  logic [9:0] cnt1000;
  logic       rst6 = 1'b0, en6 = 1'b0, co6;
  logic [2:0] cnt6;
  logic       rst1 = 1'b0, en1 = 1'b0, co1;
  logic [0:0] cnt1;
  logic       rst2 = 1'b0, en2 = 1'b0, co2;
  logic [0:0] cnt2;

  mod_m_counter #(.M(10))   u_m10   (.clk(clk), .rst(rst10),   .en(en10),   .cnt(cnt10),   .co(co10));
  mod_m_counter #(.M(1000)) u_m1000 (.clk(clk), .rst(rst1000), .en(en1000), .cnt(cnt1000), .co(co1000));
  mod_m_counter #(.M(6))    u_m6    (.clk(clk), .rst(rst6),    .en(en6),    .cnt(cnt6),    .co(co6));
  mod_m_counter #(.M(1))    u_m1    (.clk(clk), .rst(rst1),    .en(en1),    .cnt(cnt1),    .co(co1));
  mod_m_counter #(.M(2))    u_m2    (.clk(clk), .rst(rst2),    .en(en2),    .cnt(cnt2),    .co(co2));

  // Advance one clock and land 2 time units past the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++;
    if (cnt10 !== 4'd0 || co10 !== 1'b0) $display("FAIL reset_m10: cnt=%0d co=%b, want cnt=0 co=0", cnt10, co10);
    else pass_cnt++;
    total_cnt++;
    if (cnt1000 !== 10'd0 || cnt6 !== 3'd0 || cnt2 !== 1'd0 || co2 !== 1'b0)
      $display("FAIL reset_others: cnt1000=%0d cnt6=%0d cnt2=%0d co2=%b, want all 0", cnt1000, cnt6, cnt2, co2);
    else pass_cnt++;
    total_cnt++;
    if (cnt1 !== 1'd0 || co1 !== 1'b0) $display("FAIL reset_m1: cnt=%0d co=%b, want 0 0", cnt1, co1);
    else pass_cnt++;
    // Reset must dominate en across clock edges.
    en10 = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (cnt10 !== 4'd0 || co10 !== 1'b0) $display("FAIL reset_priority: cnt=%0d co=%b, want 0 0", cnt10, co10);
    else pass_cnt++;
    en10 = 1'b0;
    rst10 = 1'b1; rst1000 = 1'b1; rst6 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    #1;
  endtask

  task automatic test_continuous();
    int pulses = 0;
    int first_pulse = -1, last_pulse = -1;
    en10 = 1'b1;
    #1;
    for (int i = 0; i < 30; i++) begin
      total_cnt++;
      if (cnt10 !== 4'(i % 10) || co10 !== ((i % 10) == 9))
        $display("FAIL cont_m10[%0d]: cnt=%0d co=%b, want cnt=%0d co=%b", i, cnt10, co10, i % 10, (i % 10) == 9);
      else pass_cnt++;
      if (co10) begin
        if (first_pulse < 0) first_pulse = i;
        last_pulse = i;
        pulses++;
      end
      tick();
    end
    total_cnt++;
    if (pulses !== 3 || first_pulse !== 9 || last_pulse !== 29)
      $display("FAIL cont_pulses: count=%0d first=%0d last=%0d, want 3 9 29", pulses, first_pulse, last_pulse);
    else pass_cnt++;
    en10 = 1'b0;
  endtask

  task automatic test_toggle_en();
    int exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      en10 = (i % 2 == 1);
      #1;
      total_cnt++;
      if (cnt10 !== 4'(exp_cnt) || co10 !== (en10 && exp_cnt == 9))
        $display("FAIL toggle_m10[%0d]: cnt=%0d co=%b, want cnt=%0d co=%b", i, cnt10, co10, exp_cnt, en10 && exp_cnt == 9);
      else pass_cnt++;
      tick();
      if (en10) exp_cnt = (exp_cnt + 1) % 10;
    end
    total_cnt++;
    if (cnt10 !== 4'd0) $display("FAIL toggle_final: cnt=%0d, want 0", cnt10);
    else pass_cnt++;
    en10 = 1'b0;
  endtask

  task automatic test_m1000();
    int co_seen = 0;
    int co_at = -1;
    en1000 = 1'b1;
    for (int i = 0; i < 999; i++) tick();
    total_cnt++;
    if (cnt1000 !== 10'd999 || co1000 !== 1'b1) $display("FAIL m1000_terminal: cnt=%0d co=%b, want 999 1", cnt1000, co1000);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cnt1000 !== 10'd0 || co1000 !== 1'b0) $display("FAIL m1000_wrap: cnt=%0d co=%b, want 0 0", cnt1000, co1000);
    else pass_cnt++;
    for (int k = 0; k < 1000; k++) begin
      if (co1000) begin
        co_seen++;
        co_at = k;
      end
      tick();
    end
    total_cnt++;
    if (co_seen !== 1 || co_at !== 999) $display("FAIL m1000_period: pulses=%0d at=%0d, want 1 at 999", co_seen, co_at);
    else pass_cnt++;
    en1000 = 1'b0;
  endtask

  task automatic test_m6();
    en6 = 1'b1;
    #1;
    for (int i = 0; i < 14; i++) begin
      total_cnt++;
      if (cnt6 !== 3'(i % 6) || co6 !== ((i % 6) == 5))
        $display("FAIL m6[%0d]: cnt=%0d co=%b, want cnt=%0d co=%b", i, cnt6, co6, i % 6, (i % 6) == 5);
      else pass_cnt++;
      tick();
    end
    en6 = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    en10 = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst10 = 1'b0;
    #1;
    total_cnt++;
    if (cnt10 !== 4'd0 || co10 !== 1'b0) $display("FAIL reset_mid7: cnt=%0d co=%b, want 0 0", cnt10, co10);
    else pass_cnt++;
    rst10 = 1'b1;
    tick();
    total_cnt++;
    if (cnt10 !== 4'd1) $display("FAIL reset_release: cnt=%0d, want 1", cnt10);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) tick();
    total_cnt++;
    if (cnt10 !== 4'd9 || co10 !== 1'b1) $display("FAIL pre_reset_pulse: cnt=%0d co=%b, want 9 1", cnt10, co10);
    else pass_cnt++;
    rst10 = 1'b0;
    #1;
    total_cnt++;
    if (cnt10 !== 4'd0 || co10 !== 1'b0) $display("FAIL reset_drops_co: cnt=%0d co=%b, want 0 0", cnt10, co10);
    else pass_cnt++;
    rst10 = 1'b1;
    en10 = 1'b0;
  endtask

  task automatic test_m1();
    en1 = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (cnt1 !== 1'd0 || co1 !== 1'b1) $display("FAIL m1_en[%0d]: cnt=%0d co=%b, want 0 1", i, cnt1, co1);
      else pass_cnt++;
      tick();
    end
    en1 = 1'b0;
    #1;
    total_cnt++;
    if (cnt1 !== 1'd0 || co1 !== 1'b0) $display("FAIL m1_dis: cnt=%0d co=%b, want 0 0", cnt1, co1);
    else pass_cnt++;
  endtask

  task automatic test_m2();
    en2 = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (cnt2 !== 1'(i % 2) || co2 !== ((i % 2) == 1))
        $display("FAIL m2[%0d]: cnt=%0d co=%b, want cnt=%0d co=%b", i, cnt2, co2, i % 2, (i % 2) == 1);
      else pass_cnt++;
      tick();
    end
    en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_toggle_en();
    test_m1000();
    test_m6();
    test_reset_mid_count();
    test_m1();
    test_m2();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mod_m_counter.md
Name: mod_m_counter

Overview:
- Free-running modulo-M up-counter with count enable and a carry-out pulse on the terminal count.
- Used as an interval or timebase generator. For example, the quadrature encoder interface ties en high and uses co as a once-every-M-cycles sample strobe that clears and latches its accumulators.
- Also usable as a cascadable prescaler: drive the en of the next stage from co.

Parameters:
- M, default 10: counting modulus, an integer ≥ 1. The count sequence is 0,1,…,M-1,0,…
- CW, default max(1, $clog2(M)): width of the cnt output. It is derived from M and must not be overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  asynchronous, active-low reset. The name follows the codebase; the polarity is low-active.
- en  input  1  count enable, sampled at the clk rising edge.
- cnt  output  CW  current count, registered, range 0..M-1.
- co  output  1  carry-out, combinational, high while en=1 and cnt=M-1.

Port order is fixed as (clk, rst, en, cnt, co) for positional instantiation. cnt may be left unconnected.

Behaviour:
- Reset:
  - rst=0 forces cnt=0 immediately, without waiting for a clock edge.
  - co is then 0 if M>1.
  - Reset has priority over everything else.
  - Deassertion is taken synchronously: the first count happens at the first rising edge with rst=1 and en=1.
- Counting:
  - At each rising edge with rst=1 and en=1: if cnt=M-1 then cnt←0, otherwise cnt←cnt+1.
  - With en=0, cnt holds its value.
- Carry-out:
  - co = en AND (cnt = M-1). It is purely combinational, with zero latency relative to cnt and en.
  - With en held at 1, co is a one-cycle pulse every M cycles, high during the cycle in which the counter wraps on the next edge.
  - A consumer that registers co sees it one cycle after the wrap edge.
- With en=0 while cnt=M-1:
  - co=0 and cnt stays at M-1.
  - co reasserts in the same cycle en returns to 1.
- Wrap for non-power-of-two M: the count never reaches values ≥ M, and no state in M..2^CW-1 is reachable.
- Out-of-range state: if cnt somehow holds a value ≥ M, the next enabled edge loads 0.
- M=1:
  - cnt is constant 0 and CW=1.
  - co = en, so co is high every enabled cycle.
- M=2: cnt toggles 0/1 when enabled, and co is high while cnt=1 and en=1.
- Reset asserted mid-count:
  - cnt is cleared asynchronously, whatever its value and whatever en is.
  - A co pulse in progress drops immediately.
- No glitches on co other than those caused by en itself changing. cnt is a single register.
- Large M (e.g. 1_000_000, CW=20) must synthesize with no change in behaviour.

Test Plan:
- M=10, en=1 continuously after reset release → cnt sequence 0..9,0..; co high only while cnt=9; 3 co pulses spaced exactly 10 clk cycles apart.
- M=10, en toggled 1,0,1,0… → cnt advances only on en=1 edges; 20 cycles produce cnt=0 after 10 enables. co is high only in cycles with cnt=9 and en=1; with cnt=9 and en=0, co=0 and cnt holds at 9.
- M=1000, en=1 → cnt reaches 999, co=1 for one cycle, the next edge gives cnt=0. Pulse period is 1000 cycles (interval-timer use).
- M=6 (non-power-of-two, CW=3), en=1 → cnt never exceeds 5 and wraps 5→0; co period is 6.
- Reset mid-count: M=10, assert rst=0 between edges when cnt=7 → cnt=0 immediately (before the next edge) and co=0. After release with en=1, the first edge gives cnt=1.
- Corner cases: with M=1 and en=1, cnt stays 0 and co=1 every cycle; with M=1 and en=0, co=0. With M=2 and en=1, co alternates 0,1.
